// File: rtl/codma_mem_responder_if.sv
// codma_mem_responder_if: request/response channel bundle between the DMA initiator and the memory responder
interface codma_mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_write_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic [3:0]        req_wstrb_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/codma_mem_responder.sv
// codma_mem_responder: word-addressed byte-strobed RAM responder with wait states and address-error reporting
// Ports: clk_i clock, reset_n_i async active-low reset, bus slave modport (req_* request channel, rsp_* response channel)
module codma_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic                  clk_i,
  input logic                  reset_n_i,
  codma_mem_responder_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CNT_W = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              acc;
  logic              addr_err;
  logic              hs;
  logic [IDX_W-1:0]  idx_in;
  assign bus.req_ready_o = reset_n_i && state_q == IDLE;
  assign acc             = bus.req_valid_i && bus.req_ready_o;
  assign addr_err        = |bus.req_addr_i[1:0] || {2'b00, bus.req_addr_i[ADDR_W-1:2]} >= DEPTH_A;
  assign idx_in          = bus.req_addr_i[IDX_W+1:2];
  assign hs              = state_q == RESP && bus.rsp_ready_i;
  assign bus.rsp_valid_o = state_q == RESP;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q && state_q == RESP;
  // Reads sample the RAM on the edge entering RESP; with no wait states that is the acceptance edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (acc) begin
      state_d = WAIT_CYCLES > 0 ? WAIT : RESP;
      cnt_d   = CNT_INIT;
      idx_d   = idx_in;
      write_d = bus.req_write_i;
      err_d   = addr_err;
      rdata_d = (WAIT_CYCLES == 0 && !addr_err && !bus.req_write_i) ? mem_q[idx_in] : '0;
    end else if (state_q == WAIT) begin
      cnt_d   = cnt_q - CNT_W'(1);
      state_d = cnt_q == '0 ? RESP : WAIT;
      rdata_d = (cnt_q == '0 && !err_q && !write_q) ? mem_q[idx_q] : rdata_q;
    end else if (hs) begin
      state_d = IDLE;
      err_d   = 1'b0;
      rdata_d = '0;
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
  // Writes commit at the acceptance edge so a later reset cannot undo them; RAM is never cleared.
  always_ff @(posedge clk_i) begin
    if (acc && bus.req_write_i && !addr_err)
      for (int k = 0; k < 4; k++)
        if (bus.req_wstrb_i[k]) mem_q[idx_in][8*k +: 8] <= bus.req_wdata_i[8*k +: 8];
  end
endmodule

// File: tb/tb_codma_mem_responder.sv
// tb_codma_mem_responder: directed table-driven bench for the memory responder
module tb_codma_mem_responder;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  vec_t vecs [14];
  always #5 clk = ~clk;
  codma_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
  codma_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  codma_mem_responder #(.WAIT_CYCLES(2)) dut (.clk_i(clk), .reset_n_i(rst_n), .bus(b2.slave));
  codma_mem_responder #(.WAIT_CYCLES(0)) dut0 (.clk_i(clk), .reset_n_i(rst_n), .bus(b0.slave));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic start(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    @(negedge clk);
    b2.req_valid_i = 1'b1;
    b2.req_write_i = wr;
    b2.req_addr_i  = addr;
    b2.req_wdata_i = wdata;
    b2.req_wstrb_i = strb;
    #1 chk("req_ready_idle", b2.req_ready_o, 1);
    @(posedge clk);
    #1;
    b2.req_valid_i = 1'b0;
    b2.req_write_i = 1'b1;
    b2.req_addr_i  = ~addr;
    b2.req_wdata_i = ~wdata;
    b2.req_wstrb_i = 4'hF;
  endtask
  task automatic txn(input vec_t v, input int hold);
    int n;
    logic [31:0] rd;
    start(v.wr, v.addr, v.wdata, v.strb);
    n = 0;
    while (!b2.rsp_valid_o && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    // edges after the acceptance edge; the third edge counting acceptance itself
    chk("latency", n, 2);
    chk("rdata", b2.rsp_rdata_o, v.exp_rdata);
    chk("err", b2.rsp_err_o, v.exp_err);
    rd = b2.rsp_rdata_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", b2.rsp_valid_o, 1);
      chk("bp_rdata", b2.rsp_rdata_o, rd);
      chk("bp_ready", b2.req_ready_o, 0);
    end
    b2.rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    b2.rsp_ready_i = 1'b0;
    chk("post_valid", b2.rsp_valid_o, 0);
    chk("post_ready", b2.req_ready_o, 1);
    chk("post_rdata", b2.rsp_rdata_o, 0);
    chk("post_err", b2.rsp_err_o, 0);
  endtask
  task automatic b2b(input logic wr);
    b0.rsp_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      b0.req_valid_i = 1'b1;
      b0.req_write_i = wr;
      b0.req_addr_i  = 32'h40 + 32'(4 * (c / 2));
      b0.req_wdata_i = 32'hA500_0000 + 32'(c / 2);
      b0.req_wstrb_i = 4'hF;
      @(posedge clk);
      #1;
      if (c % 2 == 0) begin
        chk("b2b_valid", b0.rsp_valid_o, 1);
        chk("b2b_rdata", b0.rsp_rdata_o, wr ? 32'h0 : 32'hA500_0000 + 32'(c / 2));
      end else begin
        chk("b2b_idle_valid", b0.rsp_valid_o, 0);
        chk("b2b_idle_ready", b0.req_ready_o, 1);
      end
    end
    @(negedge clk);
    b0.req_valid_i = 1'b0;
    b0.rsp_ready_i = 1'b0;
  endtask
  initial begin
    int n;
    b2.req_valid_i = 1'b0; b2.req_write_i = 1'b0; b2.req_addr_i = '0; b2.req_wdata_i = '0; b2.req_wstrb_i = '0; b2.rsp_ready_i = 1'b0;
    b0.req_valid_i = 1'b0; b0.req_write_i = 1'b0; b0.req_addr_i = '0; b0.req_wdata_i = '0; b0.req_wstrb_i = '0; b0.rsp_ready_i = 1'b0;
    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b1, 32'h0,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'h22,  32'h0,        4'h0, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[8]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vecs[10] = '{1'b1, 32'h20,  32'h0,        4'h0, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[12] = '{1'b1, 32'h3FC, 32'h12345678, 4'hF, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'h12345678, 1'b0};
    #1;
    chk("rst_req_ready", b2.req_ready_o, 0);
    chk("rst_rsp_valid", b2.rsp_valid_o, 0);
    chk("rst_rdata", b2.rsp_rdata_o, 0);
    chk("rst_err", b2.rsp_err_o, 0);
    @(posedge clk);
    #1 chk("rst_req_ready_edge", b2.req_ready_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_req_ready", b2.req_ready_o, 1);
    chk("rel_req_ready_w0", b0.req_ready_o, 1);
    for (int i = 0; i < 14; i++) txn(vecs[i], i == 1 ? 5 : 0);
    b2b(1'b1);
    b2b(1'b0);
    start(1'b0, 32'h10, 32'h0, 4'h0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("midrst_valid", b2.rsp_valid_o, 0);
    chk("midrst_ready", b2.req_ready_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 chk("midrst_dropped", b2.rsp_valid_o, 0);
    end
    start(1'b0, 32'h20, 32'h0, 4'h0);
    n = 0;
    while (!b2.rsp_valid_o && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("resp_before_rst", b2.rsp_valid_o, 1);
    rst_n = 1'b0;
    #1 chk("resprst_valid", b2.rsp_valid_o, 0);
    chk("resprst_rdata", b2.rsp_rdata_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(vecs[1], 0);
    txn(vecs[11], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
